inv_mix_columns_seq: RTL and testbench
======================================

// Module: inv_mix_columns_seq
// PURPOSE
// - Iterative InvMixColumns engine for the decryption datapath of the cipher unit.
// - Takes a full 128-bit state and applies the AES inverse column mix (0e,0b,0d,09) to each column.
// - Processes COLS_PER_CYCLE columns per clock, with a valid/ready handshake on both input and output.
// - Sits between InvShiftRows/InvSubBytes/AddRoundKey in the iterative inverse round.
// PARAMETERS
// - COLS_PER_CYCLE, default 1: columns processed per cycle; legal values 1, 2, 4; other values give an elaboration error.
// PORTS
// - clk        in   1    single clock, rising edge.
// - rst_n      in   1    asynchronous, active-low reset.
// - in_valid   in   1    in_state is valid.
// - in_ready   out  1    engine can accept a state.
// - in_state   in   128  column c = [127-32c -: 32]; row 0 of each column is the MSB byte.
// - out_valid  out  1    out_state is valid.
// - out_ready  in   1    downstream accepts out_state.
// - out_state  out  128  result, same byte layout as in_state.
// - busy       out  1    high in BUSY or DONE.
// BEHAVIOUR
// - Clock and reset: single clock; reset is asynchronous and active-low.
// - Reset values:
//   - in_ready = 1; out_valid = 0; busy = 0; out_state = 0.
//   - Column counter = 0; FSM in IDLE.
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE: accept when in_valid && in_ready, capture in_state into the working register, counter = 0, go to BUSY.
//   - BUSY: each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] in place, then cnt += COLS_PER_CYCLE.
//   - BUSY -> DONE: on the cycle that processes the last column.
//   - DONE: out_valid = 1 and out_state = working register.
//   - DONE -> IDLE: when out_ready is high. in_ready rises on the following cycle.
//   - No same-cycle hand-off from DONE to accept.
// - Latency: out_valid rises 4/COLS_PER_CYCLE + 1 cycles after the accept edge (5, 3 or 2).
// - Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles when out_ready is held high.
// - in_ready is low in BUSY and DONE. in_valid is ignored there and the input is not sampled.
// - Backpressure: while out_valid && !out_ready, out_state and out_valid hold stable.
// - Column math for input bytes a0..a3, output row r:
//   - r0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3; remaining rows rotate the coefficients cyclically.
//   - GF(2^8) with polynomial 0x11B; the xtime chain stays 8-bit, reducing by 0x1B on carry-out.
// - Counter width: 2 bits; it wraps to 0 on the DONE transition.
// - Reset mid-operation: the in-flight state is discarded and outputs return to reset values asynchronously.
// - Reset deassertion: the first accept can occur on the first rising edge after rst_n goes high.
// - X on in_state while in_valid = 0 must not propagate to any output.
// STRUCTURE
// - Package aes_cipher_pkg holds:
//   - the state_t (logic [127:0]) and col_t (logic [31:0]) typedefs;
//   - the GF_POLY = 8'h1B constant;
//   - functions xtime() and gf_mul(byte, coeff);
//   - fsm_e {IDLE, BUSY, DONE}.
// - Sub-module inv_mix_column_col: combinational, one 32-bit column in and one out.
//   - Instantiated COLS_PER_CYCLE times.
//   - Fed by a column mux indexed by cnt.
// TESTING
// - Reset: hold rst_n = 0 -> in_ready = 1, out_valid = 0, out_state = 0.
//   - Deassert and send 046681e5_e0cb199a_48f8d37a_2806264c -> out_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5.
// - Identity and zero:
//   - 01010101 in every column -> unchanged.
//   - All-zero state -> all-zero result.
//   - out_valid rises exactly 5 cycles after the accept edge (COLS_PER_CYCLE = 1).
// - Backpressure: hold out_ready = 0 for 10 cycles in DONE.
//   - out_state stays stable and in_ready stays 0.
//   - After out_ready pulses high, in_ready = 1 on the next cycle.
// - Ignored input: toggle in_valid with garbage data during BUSY -> result is still the FIPS-197 vector above.
// - Mid-operation reset: assert rst_n low at cnt = 2 -> outputs reset immediately.
//   - A new vector sent after release gives the correct result with no residue from the aborted state.
// - Parameter sweep: COLS_PER_CYCLE = 2 and 4.
//   - Same vectors give identical results with latencies 3 and 2.
//   - 100 random states are checked against a reference-model inverse mix.

Source files
------------

// File: rtl/aes_cipher_pkg.sv
// Shared types, constants and GF(2^8) helpers for the cipher datapath.
package aes_cipher_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;

   // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Multiply by x in GF(2^8); the shift stays 8-bit and the carry-out is folded back in
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   // General GF(2^8) multiply by walking the xtime chain over the coefficient bits
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] coeff);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = b;
      for (int i = 0; i < 8; i++) begin
         if (coeff[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output valid-ready handshake bundle for the InvMixColumns engine.
interface inv_mix_columns_seq_if;
   import aes_cipher_pkg::*;

   logic   in_valid;
   logic   in_ready;
   state_t in_state;
   logic   out_valid;
   logic   out_ready;
   state_t out_state;

   // Producer/consumer side (upstream source and downstream sink)
   modport master (
      output in_valid,
      output in_state,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state
   );

   // Engine side
   modport slave (
      input  in_valid,
      input  in_state,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state
   );

endinterface

// File: rtl/inv_mix_column_col.sv
// Combinational inverse column mix of one 32-bit column (row 0 in the MSB byte).
module inv_mix_column_col
   import aes_cipher_pkg::*;
(
   input  col_t col_in,
   output col_t col_out
);

   // Each output row uses coefficients 0e,0b,0d,09 rotated to start at its own row
   always_comb begin
      // NOTE: every comb output gets a default first so no path can leave it unassigned (no latch).
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
         col_out[31-8*r -: 8] = gf_mul(col_in[31-8*r           -: 8], 8'h0E)
                              ^ gf_mul(col_in[31-8*((r+1) % 4) -: 8], 8'h0B)
                              ^ gf_mul(col_in[31-8*((r+2) % 4) -: 8], 8'h0D)
                              ^ gf_mul(col_in[31-8*((r+3) % 4) -: 8], 8'h09);
      end
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns engine: mixes COLS_PER_CYCLE columns of the held state per clock.
module inv_mix_columns_seq
   import aes_cipher_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   inv_mix_columns_seq_if.slave  bus,
   output logic                  busy
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // Counter step (4 wraps to 0 in two bits) and the counter value of the final step
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   fsm_e   state;
   fsm_e   state_nxt;
   logic [1:0] cnt;
   state_t work;
   state_t work_mixed;

   col_t col_in  [COLS_PER_CYCLE];
   col_t col_out [COLS_PER_CYCLE];

   // Column mux: lane k works on column cnt+k, column c lives at bits [127-32c -: 32]
   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      assign col_in[k] = work[32*(3 - int'(cnt + 2'(k))) +: 32];

      inv_mix_column_col u_col (
         .col_in  (col_in[k]),
         .col_out (col_out[k])
      );
   end

   // Working state with the current columns replaced by their mixed values
   always_comb begin
      work_mixed = work;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         work_mixed[32*(3 - int'(cnt + 2'(k))) +: 32] = col_out[k];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state: accept in IDLE, step through columns in BUSY, wait for the sink in DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)    state_nxt = BUSY;
         BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    if (bus.out_ready)   state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on accept, mix in place while BUSY, hold in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the 128-bit working register is reset as well, so an aborted state never leaves residue.
      if (!rst_n) begin
         work <= '0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  work <= bus.in_state;
                  cnt  <= '0;
               end
            end
            BUSY: begin
               work <= work_mixed;
               cnt  <= (cnt == CNT_LAST) ? 2'd0 : cnt + CNT_STEP;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from the FSM state; out_state is forced to zero outside DONE
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.out_state = (state == DONE) ? work : '0;
      busy          = (state != IDLE);
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and random checks of inv_mix_columns_seq for COLS_PER_CYCLE = 1, 2 and 4 side by side.
`timescale 1ns/1ps
module tb_inv_mix_columns_seq;
   import aes_cipher_pkg::*;

   localparam int N_DUT   = 3;
   localparam int TIMEOUT = 20;
   localparam int N_VEC   = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N_DUT-1:0]        in_valid;
   logic [N_DUT-1:0][127:0] in_state;
   logic [N_DUT-1:0]        out_ready;
   logic [N_DUT-1:0]        in_ready;
   logic [N_DUT-1:0]        out_valid;
   logic [N_DUT-1:0][127:0] out_state;
   logic [N_DUT-1:0]        busy;

   // Instance 0: 1 column/cycle, instance 1: 2, instance 2: 4
   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      inv_mix_columns_seq_if bus ();

      assign bus.in_valid  = in_valid[g];
      assign bus.in_state  = in_state[g];
      assign bus.out_ready = out_ready[g];
      assign in_ready[g]   = bus.in_ready;
      assign out_valid[g]  = bus.out_valid;
      assign out_state[g]  = bus.out_state;

      inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus),
         .busy  (busy[g])
      );
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      state_t din;
      state_t dexp;
   } vec_t;

   vec_t  vecs      [N_VEC];
   string vec_names [N_VEC];

   localparam state_t FIPS_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam state_t FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam state_t WIKI_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam state_t WIKI_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int cpc(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   // Forward MixColumns (02,03,01,01): inverse of the DUT's transform, used on random states
   function automatic logic [7:0] mul2(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
   endfunction

   function automatic state_t fwd_mix(input state_t s);
      state_t     res;
      logic [7:0] a [4];
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++) begin
            res[127-32*c-8*r -: 8] = mul2(a[r]) ^ mul2(a[(r+1)%4]) ^ a[(r+1)%4]
                                   ^ a[(r+2)%4] ^ a[(r+3)%4];
         end
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one state and step through the accept edge; in_state goes to X afterwards
   task automatic send(input int d, input state_t din);
      check($sformatf("dut%0d in_ready before accept", d), in_ready[d], 1'b1);
      in_valid[d] = 1'b1;
      in_state[d] = din;
      tick();
      in_valid[d] = 1'b0;
      in_state[d] = 'x;
   endtask

   // Cycles counted with the accept edge as cycle 1; optional garbage on the input meanwhile
   task automatic wait_out(input int d, input bit garbage, output int cyc);
      cyc = 1;
      while (!out_valid[d] && cyc < TIMEOUT) begin
         if (garbage) begin
            in_valid[d] = ~in_valid[d];
            in_state[d] = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
         cyc++;
      end
      in_valid[d] = 1'b0;
      in_state[d] = 'x;
   endtask

   task automatic run_vec(input int d, input string name, input state_t din,
                          input state_t dexp, input bit garbage);
      int cyc;
      string tag;
      tag = $sformatf("dut%0d %s", d, name);
      send(d, din);
      wait_out(d, garbage, cyc);
      check({tag, " latency"},   cyc, 4 / cpc(d) + 1);
      check({tag, " out_valid"}, out_valid[d], 1'b1);
      check({tag, " busy"},      busy[d], 1'b1);
      check({tag, " in_ready"},  in_ready[d], 1'b0);
      check({tag, " out_state"}, out_state[d], dexp);
      tick();
      check({tag, " in_ready after handoff"},  in_ready[d], 1'b1);
      check({tag, " out_valid after handoff"}, out_valid[d], 1'b0);
   endtask

   task automatic check_reset_outputs(input string name);
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("dut%0d %s in_ready", d, name),  in_ready[d], 1'b1);
         check($sformatf("dut%0d %s out_valid", d, name), out_valid[d], 1'b0);
         check($sformatf("dut%0d %s busy", d, name),      busy[d], 1'b0);
         check($sformatf("dut%0d %s out_state", d, name), out_state[d], '0);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int     cyc;
      state_t r;

      vecs[0] = '{din: FIPS_IN, dexp: FIPS_OUT};                 vec_names[0] = "fips";
      vecs[1] = '{din: {4{32'h01010101}}, dexp: {4{32'h01010101}}}; vec_names[1] = "identity";
      vecs[2] = '{din: '0, dexp: '0};                            vec_names[2] = "zero";
      vecs[3] = '{din: WIKI_IN, dexp: WIKI_OUT};                 vec_names[3] = "wiki";
      vecs[4] = '{din: 128'hc6c6c6c6_01010101_c6c6c6c6_00000000,
                  dexp: 128'hc6c6c6c6_01010101_c6c6c6c6_00000000};  vec_names[4] = "mixed_fixed";

      // Reset with X on the idle input bus
      rst_n     = 1'b0;
      in_valid  = '0;
      in_state  = 'x;
      out_ready = '1;
      #1;
      check_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;

      // First accept happens on the first edge after release
      for (int d = 0; d < N_DUT; d++)
         for (int v = 0; v < N_VEC; v++)
            run_vec(d, vec_names[v], vecs[v].din, vecs[v].dexp, 1'b0);

      // Garbage toggling on in_valid/in_state while BUSY is ignored
      for (int d = 0; d < N_DUT; d++)
         run_vec(d, "fips ignored input", FIPS_IN, FIPS_OUT, 1'b1);

      // Backpressure: DONE held for 10 cycles, then a one-cycle out_ready pulse
      out_ready[0] = 1'b0;
      send(0, FIPS_IN);
      wait_out(0, 1'b0, cyc);
      check("bp latency", cyc, 5);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp hold %0d out_valid", i), out_valid[0], 1'b1);
         check($sformatf("bp hold %0d out_state", i), out_state[0], FIPS_OUT);
         check($sformatf("bp hold %0d in_ready", i),  in_ready[0], 1'b0);
         in_valid[0] = i[0];
         in_state[0] = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      in_valid[0]  = 1'b0;
      in_state[0]  = 'x;
      check("bp still valid before pulse", out_valid[0], 1'b1);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check("bp in_ready after pulse",  in_ready[0], 1'b1);
      check("bp out_valid after pulse", out_valid[0], 1'b0);
      check("bp out_state after pulse", out_state[0], '0);
      tick();
      check("bp stays idle", in_ready[0], 1'b1);
      out_ready[0] = 1'b1;

      // Random states: forward MixColumns of the result must give the input back
      for (int d = 0; d < N_DUT; d++) begin
         for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            in_valid[d] = 1'b1;
            in_state[d] = r;
            tick();
            in_valid[d] = 1'b0;
            in_state[d] = 'x;
            wait_out(d, 1'b0, cyc);
            check($sformatf("dut%0d rand %0d roundtrip", d, i), fwd_mix(out_state[d]), r);
            tick();
         end
      end

      // Mid-operation reset when the counter sits at 2
      send(0, FIPS_IN);
      tick();
      tick();
      check("midreset busy before", busy[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      rst_n = 1'b1;
      run_vec(0, "wiki after midreset", WIKI_IN, WIKI_OUT, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
